// File: rtl/lfsr_rnd_pkg.sv
// Shared definitions for the 32-bit Galois LFSR random source and its checker:
// checker state encoding, default feedback polynomial and the LFSR step function.
package lfsr_rnd_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x, input logic [31:0] poly);
    return {x[30:0], x[31]} ^ (poly & {32{x[31]}});
  endfunction

endpackage

// File: rtl/lfsr_popcnt32.sv
// Combinational population count of a 32-bit word (6-bit result).
module lfsr_popcnt32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + 6'(data[i]);
    end
  end

endmodule

// File: rtl/lfsr_rnd_checker.sv
// Locks a local predictor onto a 32-bit Galois LFSR word stream, then counts mispredicted words.
// Define LFSR_RND_CHK_BITERR_EN to add the O_bit_err_cnt mismatched-bit counter.
module lfsr_rnd_checker
  import lfsr_rnd_pkg::*;
#(
  parameter logic [31:0] POLY       = LFSR_POLY_DEFAULT,
  parameter int          LOCK_CNT   = 4,
  parameter int          ERR_THRESH = 8
) (
  input  logic        clk,
  input  logic        I_reset,
  input  logic        I_valid,
  input  logic [31:0] I_data,
  input  logic        I_clear,
  output logic        O_locked,
  output logic        O_mismatch,
  output logic [15:0] O_err_cnt
`ifdef LFSR_RND_CHK_BITERR_EN
  ,
  output logic [31:0] O_bit_err_cnt
`endif
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT);
  localparam logic [7:0] MISS_LAST = 8'(ERR_THRESH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] acc);
    return (acc == 16'hffff) ? acc : acc + 16'd1;
  endfunction

`ifdef LFSR_RND_CHK_BITERR_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [5:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {27'd0, inc};
    return sum[32] ? 32'hffff_ffff : sum[31:0];
  endfunction
`endif

  state_t      state_p1, state_nxt;
  logic [31:0] pred_p1, pred_nxt;
  logic [3:0]  match_cnt_p1, match_nxt;
  logic [7:0]  miss_cnt_p1, miss_nxt;
  logic        mismatch_p1, mismatch_nxt;
  logic [15:0] err_cnt_p1, err_nxt;

  logic [31:0] pred_step, seed_step;
  logic [3:0]  match_inc;
  logic [7:0]  miss_inc;
  logic        word_miss;

  assign pred_step = lfsr_step(pred_p1, POLY);
  assign seed_step = lfsr_step(I_data, POLY);
  assign match_inc = match_cnt_p1 + 4'd1;
  assign miss_inc  = miss_cnt_p1 + 8'd1;
  assign word_miss = (I_data != pred_p1);

`ifdef LFSR_RND_CHK_BITERR_EN
  logic [31:0] bit_err_cnt_p1, bit_err_nxt;
  logic [31:0] diff_bits;
  logic [5:0]  pop_cnt;

  assign diff_bits = I_data ^ pred_p1;

  lfsr_popcnt32 u_popcnt (
    .data  (diff_bits),
    .count (pop_cnt)
  );
`endif

  // Stage p0 -> p1: next-state decode from the sampled word
  always_comb begin
    state_nxt    = state_p1;
    pred_nxt     = pred_p1;
    match_nxt    = match_cnt_p1;
    miss_nxt     = miss_cnt_p1;
    mismatch_nxt = 1'b0;
    err_nxt      = err_cnt_p1;
`ifdef LFSR_RND_CHK_BITERR_EN
    bit_err_nxt  = bit_err_cnt_p1;
`endif
    if (I_valid) begin
      case (state_p1)
        HUNT: begin
          // Zero is a fixed point of the LFSR and cannot seed a sequence
          if (I_data != '0) begin
            pred_nxt  = seed_step;
            match_nxt = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (!word_miss) begin
            pred_nxt = pred_step;
            if (match_inc == LOCK_LAST) begin
              match_nxt = '0;
              state_nxt = LOCKED;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            pred_nxt  = seed_step;
            match_nxt = '0;
            if (I_data == '0) begin
              state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          pred_nxt = pred_step;
          if (word_miss) begin
            mismatch_nxt = 1'b1;
            err_nxt      = sat_inc16(err_cnt_p1);
`ifdef LFSR_RND_CHK_BITERR_EN
            bit_err_nxt  = sat_add32(bit_err_cnt_p1, pop_cnt);
`endif
            if (miss_inc == MISS_LAST) begin
              miss_nxt  = '0;
              state_nxt = HUNT;
            end else begin
              miss_nxt = miss_inc;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          match_nxt = '0;
          miss_nxt  = '0;
        end
      endcase
    end
    // A clear coinciding with a mismatch keeps that mismatch's contribution
    if (I_clear) begin
      err_nxt     = mismatch_nxt ? 16'd1 : 16'd0;
`ifdef LFSR_RND_CHK_BITERR_EN
      bit_err_nxt = mismatch_nxt ? {26'd0, pop_cnt} : 32'd0;
`endif
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (I_reset) begin
      state_p1       <= HUNT;
      pred_p1        <= '0;
      match_cnt_p1   <= '0;
      miss_cnt_p1    <= '0;
      mismatch_p1    <= 1'b0;
      err_cnt_p1     <= '0;
`ifdef LFSR_RND_CHK_BITERR_EN
      bit_err_cnt_p1 <= '0;
`endif
    end else begin
      state_p1       <= state_nxt;
      pred_p1        <= pred_nxt;
      match_cnt_p1   <= match_nxt;
      miss_cnt_p1    <= miss_nxt;
      mismatch_p1    <= mismatch_nxt;
      err_cnt_p1     <= err_nxt;
`ifdef LFSR_RND_CHK_BITERR_EN
      bit_err_cnt_p1 <= bit_err_nxt;
`endif
    end
  end

  assign O_locked   = (state_p1 == LOCKED);
  assign O_mismatch = mismatch_p1;
  assign O_err_cnt  = err_cnt_p1;
`ifdef LFSR_RND_CHK_BITERR_EN
  assign O_bit_err_cnt = bit_err_cnt_p1;
`endif

endmodule
